// File: rtl/cache_pkg.sv
// Shared cache definitions: miss-handler state encoding and line geometry helpers
// used by the miss handler, way arrays and eviction policy.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } miss_state_t;

  function automatic int words_f(input int block_size, input int data_width);
    return (block_size * 8) / data_width;
  endfunction

  function automatic int offset_bits_f(input int block_size);
    return $clog2(block_size);
  endfunction

  // Default geometry: 32-byte lines of 32-bit words.
  localparam int WORDS       = words_f(32, 32);
  localparam int OFFSET_BITS = offset_bits_f(32);

endpackage

// File: rtl/cache_wb_buffer.sv
// Victim-line read prefetch for writeback: issues array reads one cycle ahead and
// holds at most one word so the memory write stream survives wready stalls.
module cache_wb_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  active,
  output logic                  vic_rd_en,
  output logic [IDX_W-1:0]      vic_rd_idx,
  input  logic [DATA_WIDTH-1:0] vic_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic                  pend;
  logic                  full;
  logic                  issued_all;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  fire;

  // pend: array data for the last issued read is on vic_rd_data this cycle.
  assign out_valid  = active && (full || pend);
  assign out_data   = full ? buf_data : (pend ? vic_rd_data : '0);
  assign fire       = out_valid && out_ready;
  assign vic_rd_en  = active && !issued_all && ((full || pend) ? fire : 1'b1);
  assign vic_rd_idx = vic_rd_en ? rd_idx : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      full       <= 1'b0;
      issued_all <= 1'b0;
      rd_idx     <= '0;
      buf_data   <= '0;
    end else if (!active) begin
      pend       <= 1'b0;
      full       <= 1'b0;
      issued_all <= 1'b0;
      rd_idx     <= '0;
    end else begin
      pend <= vic_rd_en;
      if (fire) begin
        full <= 1'b0;
      end else if (pend) begin
        // read data is only valid for one cycle; park it while the sink stalls
        full     <= 1'b1;
        buf_data <= vic_rd_data;
      end
      if (vic_rd_en) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        if (rd_idx == LAST_IDX) issued_all <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: optional dirty-victim writeback followed by a line fill.
//   state   | meaning
//   IDLE    | waiting for a miss, miss_ready high
//   WB_REQ  | write request for the victim line
//   WB_DATA | streaming victim words to memory
//   RD_REQ  | read request for the missing line
//   RD_DATA | forwarding read beats into the fill port
//   DONE    | one-cycle fill_done with the line tag address
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       miss_valid,
  output logic                                       miss_ready,
  input  logic [ADDRESS_WIDTH-1:0]                   miss_addr,
  input  logic [$clog2(NUM_WAYS)-1:0]                miss_way,
  input  logic                                       victim_dirty,
  input  logic [ADDRESS_WIDTH-1:0]                   victim_addr,
  output logic                                       vic_rd_en,
  output logic [$clog2(BLOCK_SIZE*8/DATA_WIDTH)-1:0] vic_rd_idx,
  input  logic [DATA_WIDTH-1:0]                      vic_rd_data,
  output logic                                       mem_req_valid,
  input  logic                                       mem_req_ready,
  output logic                                       mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]                   mem_req_addr,
  output logic                                       mem_wvalid,
  input  logic                                       mem_wready,
  output logic [DATA_WIDTH-1:0]                      mem_wdata,
  input  logic                                       mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                      mem_rdata,
  output logic                                       fill_we,
  output logic [$clog2(NUM_WAYS)-1:0]                fill_way,
  output logic [$clog2(BLOCK_SIZE*8/DATA_WIDTH)-1:0] fill_idx,
  output logic [DATA_WIDTH-1:0]                      fill_data,
  output logic [ADDRESS_WIDTH-1:0]                   fill_tag_addr,
  output logic                                       fill_done,
  output logic                                       busy
);

  localparam int LINE_WORDS = words_f(BLOCK_SIZE, DATA_WIDTH);
  localparam int OFF_W      = offset_bits_f(BLOCK_SIZE);
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << OFF_W;

  miss_state_t                  state, nxt;
  logic [ADDRESS_WIDTH-1:0]     miss_line;
  logic [ADDRESS_WIDTH-1:0]     vic_line;
  logic [$clog2(NUM_WAYS)-1:0]  lat_way;
  logic [IDX_W-1:0]             beat_cnt;
  logic                         beat_last;
  logic                         accept;
  logic                         wb_valid;
  logic [DATA_WIDTH-1:0]        wb_data;
  logic                         wfire;

  assign miss_ready = (state == IDLE);
  assign busy       = !miss_ready;
  assign accept     = miss_valid && miss_ready;
  assign beat_last  = (beat_cnt == IDX_W'(LINE_WORDS - 1));

  cache_wb_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_wb_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .active      (state == WB_DATA),
    .vic_rd_en   (vic_rd_en),
    .vic_rd_idx  (vic_rd_idx),
    .vic_rd_data (vic_rd_data),
    .out_valid   (wb_valid),
    .out_ready   (mem_wready),
    .out_data    (wb_data)
  );

  assign mem_wvalid = wb_valid;
  assign mem_wdata  = wb_valid ? wb_data : '0;
  assign wfire      = mem_wvalid && mem_wready;

  // Fill path is a straight combinational pass of the read beat.
  assign fill_we   = (state == RD_DATA) && mem_rvalid;
  assign fill_way  = fill_we ? lat_way : '0;
  assign fill_idx  = fill_we ? beat_cnt : '0;
  assign fill_data = fill_we ? mem_rdata : '0;

  always_comb begin
    nxt           = state;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    fill_done     = 1'b0;
    fill_tag_addr = '0;
    case (state)
      IDLE: begin
        if (accept) nxt = victim_dirty ? WB_REQ : RD_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = vic_line;
        if (mem_req_ready) nxt = WB_DATA;
      end
      WB_DATA: begin
        if (wfire && beat_last) nxt = RD_REQ;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = miss_line;
        if (mem_req_ready) nxt = RD_DATA;
      end
      RD_DATA: begin
        if (fill_we && beat_last) nxt = DONE;
      end
      DONE: begin
        fill_done     = 1'b1;
        fill_tag_addr = miss_line;
        nxt           = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      miss_line <= '0;
      vic_line  <= '0;
      lat_way   <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        miss_line <= miss_addr & LINE_MASK;
        vic_line  <= victim_addr & LINE_MASK;
        lat_way   <= miss_way;
      end
      if ((nxt == WB_DATA || nxt == RD_DATA) && (nxt != state)) begin
        beat_cnt <= '0;
      end else if (wfire || fill_we) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: clean and dirty misses, write stalls,
// spurious read beats, held miss requests and reset during a fill.
module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_addr;
  logic [1:0]  miss_way;
  logic        victim_dirty;
  logic [31:0] victim_addr;
  logic        vic_rd_en;
  logic [2:0]  vic_rd_idx;
  logic [31:0] vic_rd_data = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [1:0]  fill_way;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic [31:0] fill_tag_addr;
  logic        fill_done;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] vic_base = 32'hC0DE_0000;
  logic [3:0]  wr_pat = 4'b1001;
  int          exp_beat;
  int          loop_cycles;

  cache_miss_handler #(
    .NUM_WAYS(4), .DATA_WIDTH(32), .BLOCK_SIZE(32), .ADDRESS_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_way(miss_way), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .vic_rd_en(vic_rd_en), .vic_rd_idx(vic_rd_idx), .vic_rd_data(vic_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_way(fill_way), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_tag_addr(fill_tag_addr), .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Victim line storage: word k reads back as vic_base + k one cycle after the request.
  always @(posedge clk) if (vic_rd_en) vic_rd_data <= vic_base + 32'(vic_rd_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic accept(input logic [31:0] addr, input logic [1:0] way,
                        input logic dirty, input logic [31:0] vaddr);
    cyc();
    miss_valid = 1'b1; miss_addr = addr; miss_way = way;
    victim_dirty = dirty; victim_addr = vaddr;
    #1;
    chk("accept_ready", 32'(miss_ready), 32'd1);
  endtask

  task automatic read_phase(input logic [31:0] line, input logic [1:0] way, input logic [31:0] base);
    cyc(); miss_valid = 1'b0; mem_rvalid = 1'b0; #1;
    chk("rdreq_valid", 32'(mem_req_valid), 32'd1);
    chk("rdreq_write", 32'(mem_req_write), 32'd0);
    chk("rdreq_addr", mem_req_addr, line);
    for (int k = 0; k < 8; k++) begin
      cyc(); mem_rvalid = 1'b1; mem_rdata = base + 32'(k); #1;
      chk("fill_we", 32'(fill_we), 32'd1);
      chk("fill_idx", 32'(fill_idx), 32'(k));
      chk("fill_way", 32'(fill_way), 32'(way));
      chk("fill_data", fill_data, base + 32'(k));
      chk("fill_done_early", 32'(fill_done), 32'd0);
    end
    cyc(); mem_rvalid = 1'b0; #1;
    chk("fill_done", 32'(fill_done), 32'd1);
    chk("fill_tag", fill_tag_addr, line);
    cyc(); #1;
    chk("done_pulse", 32'(fill_done), 32'd0);
    chk("back_idle_ready", 32'(miss_ready), 32'd1);
    chk("back_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    miss_valid = 1'b0; miss_addr = '0; miss_way = '0; victim_dirty = 1'b0; victim_addr = '0;
    mem_req_ready = 1'b1; mem_wready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset values
    repeat (2) cyc();
    #1;
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_vic_rd_en", 32'(vic_rd_en), 32'd0);
    chk("rst_fill_we", 32'(fill_we), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    cyc(); reset_n = 1'b1; #1;
    chk("post_rst_ready", 32'(miss_ready), 32'd1);

    // clean miss 0x1234 way 2, spurious rvalid in IDLE and RD_REQ, miss_valid held while busy
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("spur_idle_fill_we", 32'(fill_we), 32'd0);
    cyc();
    miss_valid = 1'b1; miss_addr = 32'h0000_1234; miss_way = 2'd2;
    victim_dirty = 1'b0; victim_addr = 32'h9999_0000; #1;
    chk("clean_accept_ready", 32'(miss_ready), 32'd1);
    chk("clean_accept_fill_we", 32'(fill_we), 32'd0);
    cyc(); #1;
    chk("clean_req_valid", 32'(mem_req_valid), 32'd1);
    chk("clean_req_write", 32'(mem_req_write), 32'd0);
    chk("clean_req_addr", mem_req_addr, 32'h0000_1220);
    chk("held_miss_ready", 32'(miss_ready), 32'd0);
    chk("clean_busy", 32'(busy), 32'd1);
    chk("spur_rdreq_fill_we", 32'(fill_we), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(k);
      if (k == 4) miss_valid = 1'b0;
      #1;
      chk("clean_fill_we", 32'(fill_we), 32'd1);
      chk("clean_fill_idx", 32'(fill_idx), 32'(k));
      chk("clean_fill_way", 32'(fill_way), 32'd2);
      chk("clean_fill_data", fill_data, 32'hA0 + 32'(k));
      chk("busy_miss_ready", 32'(miss_ready), 32'd0);
    end
    cyc(); mem_rvalid = 1'b0; #1;
    chk("clean_fill_done_c10", 32'(fill_done), 32'd1);
    chk("clean_fill_tag", fill_tag_addr, 32'h0000_1220);
    cyc(); #1;
    chk("clean_done_pulse", 32'(fill_done), 32'd0);
    chk("clean_ready_after", 32'(miss_ready), 32'd1);
    cyc(); #1;
    chk("no_second_accept", 32'(busy), 32'd0);

    // dirty miss, victim 0x8040, write request held until ready
    vic_base = 32'hC0DE_0000; mem_req_ready = 1'b0; mem_wready = 1'b1;
    accept(32'h0000_2000, 2'd1, 1'b1, 32'h0000_8040);
    cyc(); miss_valid = 1'b0; #1;
    chk("wbreq_valid", 32'(mem_req_valid), 32'd1);
    chk("wbreq_write", 32'(mem_req_write), 32'd1);
    chk("wbreq_addr", mem_req_addr, 32'h0000_8040);
    cyc(); mem_req_ready = 1'b1; #1;
    chk("wbreq_hold_valid", 32'(mem_req_valid), 32'd1);
    chk("wbreq_hold_addr", mem_req_addr, 32'h0000_8040);
    cyc(); #1;
    chk("wb_first_rd_en", 32'(vic_rd_en), 32'd1);
    chk("wb_first_rd_idx", 32'(vic_rd_idx), 32'd0);
    chk("wb_bubble", 32'(mem_wvalid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk("wb_wvalid", 32'(mem_wvalid), 32'd1);
      chk("wb_wdata", mem_wdata, 32'hC0DE_0000 + 32'(k));
      chk("wb_rd_en", 32'(vic_rd_en), (k < 7) ? 32'd1 : 32'd0);
      if (k < 7) chk("wb_rd_idx", 32'(vic_rd_idx), 32'(k + 1));
    end
    read_phase(32'h0000_2000, 2'd1, 32'h5500);

    // dirty miss with mem_wready cycling 1,0,0,1
    vic_base = 32'hBEEF_0000;
    accept(32'h0000_3010, 2'd3, 1'b1, 32'h0000_4000);
    cyc(); miss_valid = 1'b0; #1;
    chk("wbreq2_addr", mem_req_addr, 32'h0000_4000);
    exp_beat = 0;
    loop_cycles = 0;
    for (int i = 0; i < 40 && exp_beat < 8; i++) begin
      cyc(); mem_wready = wr_pat[3 - (i % 4)]; #1;
      if (mem_wvalid) begin
        chk("wb_stall_data", mem_wdata, 32'hBEEF_0000 + 32'(exp_beat));
        if (mem_wready) exp_beat++;
      end
      loop_cycles = i + 1;
    end
    chk("wb_stall_beats", 32'(exp_beat), 32'd8);
    chk("wb_stall_cycles", 32'(loop_cycles), 32'd17);
    mem_wready = 1'b1;
    read_phase(32'h0000_3000, 2'd3, 32'h7700);

    // reset asserted at read beat 4, then a fresh miss
    accept(32'h0000_5000, 2'd1, 1'b0, 32'h0);
    cyc(); miss_valid = 1'b0; #1;
    chk("rst_test_req_addr", mem_req_addr, 32'h0000_5000);
    for (int k = 0; k < 4; k++) begin
      cyc(); mem_rvalid = 1'b1; mem_rdata = 32'(k); #1;
      chk("pre_rst_fill_idx", 32'(fill_idx), 32'(k));
    end
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'd4; reset_n = 1'b0; #1;
    chk("midrst_fill_we", 32'(fill_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(miss_ready), 32'd1);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_fill_done", 32'(fill_done), 32'd0);
    cyc(); reset_n = 1'b1; #1;
    chk("postrst_fill_we", 32'(fill_we), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(); mem_rvalid = k[0]; #1;
      chk("postrst_no_done", 32'(fill_done), 32'd0);
      chk("postrst_no_fill", 32'(fill_we), 32'd0);
      chk("postrst_no_req", 32'(mem_req_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    accept(32'h0000_6004, 2'd0, 1'b0, 32'h0);
    read_phase(32'h0000_6000, 2'd0, 32'h1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
